sr_stack_arb: RTL
=================

# sr_stack_arb

Two-port arbiter that shares the single 8x8 hardware stack between the CPU core (port 0) and the debug/host port (port 1). It accepts one push or pop request at a time, arbitrates round-robin, issues exactly one push or pop strobe to the stack, and returns the popped data or an error flag. It sits between the requesters and the stack's push/pop/in/out/valid/full pins and is the only block that drives those pins.

## Interface

- `DATA_W`, 8: stack word width.
- `clk`, in, 1: clock; all state changes on its rising edge.
- `rst`, in, 1: reset; synchronous and active-high.
- `req0_valid` / `req1_valid`, in, 1 each: request pending on port 0 / port 1.
- `req0_op` / `req1_op`, in, 1 each: 0 = push, 1 = pop.
- `req0_wdata` / `req1_wdata`, in, DATA_W each: push data.
- `req0_ready` / `req1_ready`, out, 1 each: request accepted this cycle.
- `rsp0_valid` / `rsp1_valid`, out, 1 each: one-cycle completion pulse.
- `rsp0_rdata` / `rsp1_rdata`, out, DATA_W each: popped word. 0 for a push or an error.
- `rsp0_err` / `rsp1_err`, out, 1 each: overflow or underflow. Qualified by `rspN_valid`.
- `stk_push`, out, 1: push strobe to the stack.
- `stk_pop`, out, 1: pop strobe to the stack.
- `stk_in`, out, DATA_W: push data to the stack.
- `stk_valid`, in, 1: stack is non-empty.
- `stk_full`, in, 1: stack is full.
- `stk_out`, in, DATA_W: current top of stack.

## Operation

- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- **IDLE**
  - If any `reqN_valid` is high, grant one port. Assert its `reqN_ready` combinationally in the same cycle.
  - Latch the op, wdata and port id.
  - Go to ISSUE.
- **Arbitration**
  - `last` is a 1-bit register holding the last granted port.
  - When both ports request, grant the port that is not `last`.
  - When one port requests, grant it regardless of `last`.
  - `last` updates on every grant. Reset value is 1, so port 0 wins the first tie.
- **ISSUE** (exactly one cycle, then RESP)
  - Push with `stk_full`=0: `stk_push`=1, `stk_in`=latched wdata.
  - Push with `stk_full`=1: no strobe; set err.
  - Pop with `stk_valid`=1: capture `stk_out` into the rdata register; `stk_pop`=1.
  - Pop with `stk_valid`=0: no strobe; set err; rdata=0.
- **RESP** (one cycle, then IDLE)
  - `rspN_valid`=1 on the latched port only, with rdata and err.
  - `reqN_ready`=0 on both ports.
- Requesters must hold `valid`, `op` and `wdata` stable until `ready` is seen.
- `stk_push` and `stk_pop` are never high together.
- Both strobes are decoded from registered state only (no combinational path from `req*`).
- `stk_in` is 0 whenever `stk_push`=0.

## Timing

- Request accepted in cycle N (IDLE, `ready`=1).
- Stack strobe in cycle N+1 (ISSUE).
- Response pulse in cycle N+2 (RESP).
- Next accept no earlier than cycle N+3. Peak throughput is one op per 3 cycles.
- The full/empty check uses `stk_full` and `stk_valid` as sampled in the ISSUE cycle.
- **Reset values**
  - All `reqN_ready`, `rspN_valid`, `rspN_err`: 0.
  - All `rspN_rdata`: 0.
  - `stk_push`, `stk_pop`, `stk_in`: 0.
  - State = IDLE, `last` = 1.
- **Reset mid-operation**
  - `rst` sampled high in IDLE or ISSUE: the next cycle is IDLE. No strobe and no response for the aborted op.
  - `rst` sampled high during RESP: the pulse still shows in that cycle, but no further outputs follow.
- A requester whose `valid` drops before its `ready` is treated as withdrawn. No response is generated for it.

## Structure

- Add to the shared `sr_cpu.vh` header:
  - `STK_OP_PUSH` = 1'b0, `STK_OP_POP` = 1'b1.
  - State encodings `STKARB_IDLE` = 2'd0, `STKARB_ISSUE` = 2'd1, `STKARB_RESP` = 2'd2.
- One sub-module, `sr_rr_arb2`: combinational two-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt[1:0]` (one-hot or zero), `gnt_id`.
- The FSM, latches, full/empty checks and response registers live in `sr_stack_arb`.

## Test plan

- **Single push then pop.** Port 0 pushes 0xA5 on an empty stack → `stk_push` high in N+1 with `stk_in`=0xA5; `rsp0_valid` in N+2 with err=0. Port 0 then pops → `stk_pop` high one cycle; `rsp0_rdata`=0xA5, err=0.
- **Tie arbitration.** Both ports request push every cycle after reset (0x11 on port 0, 0x22 on port 1) → grant order 0,1,0,1. The stack receives 0x11, 0x22, 0x11, 0x22. Each port gets one response per grant.
- **Overflow.** Push 8 words, then a 9th push with 0x99 while `stk_full`=1 → no `stk_push` pulse; `rsp_err`=1; `rsp_rdata`=0. A following pop returns the 8th word.
- **Underflow.** Pop with `stk_valid`=0 → no `stk_pop`; err=1; rdata=0. Then push 0x3C and pop → 0x3C, err=0.
- **Reset mid-op.** Assert `rst` in the ISSUE cycle of a push → no strobe and no `rsp_valid`. All outputs are 0 the next cycle. After release, a tie grants port 0 first.
- **Protocol invariants** (checked every cycle by assertion):
  - `stk_push` and `stk_pop` never both high.
  - At most one `ready` and one `rsp_valid` high at a time.
  - Exactly one response per accepted request.

Source files
------------

// File: rtl/sr_stack_arb_pkg.sv
// Shared definitions for the stack arbiter: op codes and FSM state encoding.
package sr_stack_arb_pkg;

   localparam logic STK_OP_PUSH = 1'b0;
   localparam logic STK_OP_POP  = 1'b1;

   typedef enum logic [1:0] {
      STKARB_IDLE  = 2'd0,
      STKARB_ISSUE = 2'd1,
      STKARB_RESP  = 2'd2
   } stkArbState_t;

endpackage

// File: rtl/sr_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the port that was not granted last wins.
module sr_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            gnt_id = 1'b0;
         end
         2'b10: begin
            gnt    = 2'b10;
            gnt_id = 1'b1;
         end
         2'b11: begin
            gnt    = last ? 2'b01 : 2'b10;
            gnt_id = ~last;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sr_stack_arb.sv
// Shares the single hardware stack between the CPU core (port 0) and the debug port (port 1),
// one push/pop at a time: accept, issue one strobe, then return a one-cycle response.
module sr_stack_arb
   import sr_stack_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_op,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_op,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic              stk_push,
   output logic              stk_pop,
   output logic [DATA_W-1:0] stk_in,
   input  logic              stk_valid,
   input  logic              stk_full,
   input  logic [DATA_W-1:0] stk_out
);

   stkArbState_t      state, stateNext;
   logic              lastGnt;
   logic              latPort;
   logic              latOp;
   logic [DATA_W-1:0] latData;
   logic [1:0]        rspValid;
   logic              rspErr;
   logic [DATA_W-1:0] rspData;

   logic [1:0]        gnt;
   logic              gntId;
   logic              accept;
   logic              issueErr;
   logic [DATA_W-1:0] issueData;

   sr_rr_arb2 uArb (
      .req    ({req1_valid, req0_valid}),
      .last   (lastGnt),
      .gnt    (gnt),
      .gnt_id (gntId)
   );

   // Next state, handshake and stack strobes; rst suppresses anything that would start or commit an op.
   always_comb begin
      stateNext  = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      stk_in     = '0;
      issueErr   = 1'b0;
      issueData  = '0;
      case (state)
         STKARB_IDLE: begin
            if ((req0_valid || req1_valid) && !rst) begin
               accept     = 1'b1;
               req0_ready = gnt[0];
               req1_ready = gnt[1];
               stateNext  = STKARB_ISSUE;
            end
         end
         STKARB_ISSUE: begin
            stateNext = STKARB_RESP;
            if (latOp == STK_OP_PUSH) begin
               if (stk_full) begin
                  issueErr = 1'b1;
               end else if (!rst) begin
                  stk_push = 1'b1;
                  stk_in   = latData;
               end
            end else if (latOp == STK_OP_POP) begin
               if (stk_valid) begin
                  issueData = stk_out;
                  stk_pop   = !rst;
               end else begin
                  issueErr = 1'b1;
               end
            end
         end
         STKARB_RESP: stateNext = STKARB_IDLE;
         default:     stateNext = STKARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= STKARB_IDLE;
         lastGnt  <= 1'b1;
         latPort  <= 1'b0;
         latOp    <= STK_OP_PUSH;
         latData  <= '0;
         rspValid <= 2'b00;
         rspErr   <= 1'b0;
         rspData  <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            lastGnt <= gntId;
            latPort <= gntId;
            latOp   <= gntId ? req1_op : req0_op;
            latData <= gntId ? req1_wdata : req0_wdata;
         end
         // Response registers hold a value only during the RESP cycle.
         rspValid <= 2'b00;
         rspErr   <= 1'b0;
         rspData  <= '0;
         if (state == STKARB_ISSUE) begin
            rspValid <= latPort ? 2'b10 : 2'b01;
            rspErr   <= issueErr;
            rspData  <= issueData;
         end
      end
   end

   assign rsp0_valid = rspValid[0];
   assign rsp1_valid = rspValid[1];
   assign rsp0_err   = rspValid[0] & rspErr;
   assign rsp1_err   = rspValid[1] & rspErr;
   assign rsp0_rdata = rspValid[0] ? rspData : '0;
   assign rsp1_rdata = rspValid[1] ? rspData : '0;

endmodule
